acp_job_scheduler: RTL

Sequences copy jobs through the AXI DataMover that sits between the ACP port and the accelerator streams. Software writes SRC/DST/LEN descriptors over the AXI-lite set/get register bus into a small descriptor queue. For each queued job the block issues a paired mm2s (host-to-stream) and s2mm (stream-to-host) command and collects both status beats. It then reports completion and errors and raises one interrupt. It replaces the two free-running stream masters and the shared status-OR interrupt.

---
 rtl/acp_sched_pkg.sv | 49 ++++
 rtl/acp_job_scheduler_desc_fifo.sv | 52 +++++
 rtl/acp_job_scheduler.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/acp_sched_pkg.sv
// Shared constants, FSM encoding and command formatting for the ACP job scheduler.
package acp_sched_pkg;

  localparam int REG_SRC    = 0;
  localparam int REG_DST    = 1;
  localparam int REG_LEN    = 2;
  localparam int REG_STATUS = 3;
  localparam int REG_CTRL   = 4;

  localparam int LEN_W  = 23;
  localparam int DESC_W = 32 + 32 + LEN_W;
  localparam int CMD_W  = 72;

  localparam int CMD_TYPE_BIT = 23;
  localparam int CMD_EOF_BIT  = 30;
  localparam int CMD_ADDR_LSB = 32;
  localparam int CMD_TAG_LSB  = 64;

  localparam int STS_INTERR = 4;
  localparam int STS_DECERR = 5;
  localparam int STS_SLVERR = 6;
  localparam int STS_OKAY   = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic logic [CMD_W-1:0] fmt_cmd(input logic [31:0] addr,
                                              input logic [LEN_W-1:0] btt,
                                              input logic [3:0] tag);
    logic [CMD_W-1:0] c;
    c = '0;
    c[LEN_W-1:0]             = btt;
    c[CMD_TYPE_BIT]          = 1'b1;
    c[CMD_EOF_BIT]           = 1'b1;
    c[CMD_ADDR_LSB +: 32]    = addr;
    c[CMD_TAG_LSB +: 4]      = tag;
    return c;
  endfunction

  // A status beat is bad on missing OKAY, any error flag, or a stale tag.
  function automatic logic sts_bad(input logic [7:0] s, input logic [3:0] tag);
    return !s[STS_OKAY] || s[STS_INTERR] || s[STS_DECERR] || s[STS_SLVERR] || (s[3:0] != tag);
  endfunction

endpackage

// File: rtl/acp_job_scheduler_desc_fifo.sv
// Synchronous descriptor FIFO; head entry stays put until the job that uses it is popped.
module desc_fifo #(
  parameter int W  = 87,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);
  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          do_push, do_pop;

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    level_d  = level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (level_q == (AW+1)'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;

endmodule

// File: rtl/acp_job_scheduler.sv
// Queues SRC/DST/LEN descriptors and runs each as a paired mm2s/s2mm DataMover job.
module acp_job_scheduler
  import acp_sched_pkg::*;
#(
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_QDEPTH_LOG2      = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] set_addr,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] set_data,
  input  logic                          set_stb,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] get_addr,
  output logic [C_S_AXI_DATA_WIDTH-1:0] get_data,
  input  logic                          get_stb,
  output logic                          h2s_cmd_tvalid,
  input  logic                          h2s_cmd_tready,
  output logic [71:0]                   h2s_cmd_tdata,
  input  logic                          h2s_sts_tvalid,
  output logic                          h2s_sts_tready,
  input  logic [7:0]                    h2s_sts_tdata,
  output logic                          s2h_cmd_tvalid,
  input  logic                          s2h_cmd_tready,
  output logic [71:0]                   s2h_cmd_tdata,
  input  logic                          s2h_sts_tvalid,
  output logic                          s2h_sts_tready,
  input  logic [7:0]                    s2h_sts_tdata,
  output logic                          irq
);
  // Streams use AXI-Stream rules: a beat transfers on a cycle where tvalid & tready
  // are both high; a raised cmd tvalid holds with stable tdata until it transfers.

  localparam int LVL_W = C_QDEPTH_LOG2 + 1;

  state_e state_q, state_d;
  logic [31:0] src_q, src_d, dst_q, dst_d;
  logic        irq_en_q, irq_en_d, irq_pend_q, irq_pend_d;
  logic        err_cfg_q, err_cfg_d, err_xfer_q, err_xfer_d;
  logic [7:0]  done_cnt_q, done_cnt_d, bad_byte_q, bad_byte_d;
  logic [3:0]  tag_q, tag_d;
  logic [71:0] h_cmd_q, h_cmd_d, s_cmd_q, s_cmd_d;
  logic        h_vld_q, h_vld_d, s_vld_q, s_vld_d;
  logic        h_done_q, h_done_d, s_done_q, s_done_d;
  logic [7:0]  h_sts_q, h_sts_d, s_sts_q, s_sts_d;

  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DESC_W-1:0] fifo_rdata;
  logic [LVL_W-1:0]  fifo_level;
  logic              busy, load, sts_rdy, issue_done;
  logic              wr_len, wr_ctrl, len_ok, h_bad, s_bad;
  logic [31:0]       status_w;
  logic              unused_bits;

  assign wr_len  = set_stb && (set_addr[4:2] == 3'(REG_LEN));
  assign wr_ctrl = set_stb && (set_addr[4:2] == 3'(REG_CTRL));
  assign len_ok  = (set_data != '0) && (set_data[C_S_AXI_DATA_WIDTH-1:LEN_W] == '0);
  assign fifo_push = wr_len && len_ok && (!fifo_full || fifo_pop);

  desc_fifo #(.W(DESC_W), .AW(C_QDEPTH_LOG2)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata ({src_q, dst_q, set_data[LEN_W-1:0]}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  assign issue_done = (!h_vld_q || h2s_cmd_tready) && (!s_vld_q || s2h_cmd_tready);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (!fifo_empty) state_d = ST_ISSUE;
      ST_ISSUE: if (issue_done) state_d = ST_WAIT;
      ST_WAIT:  if (h_done_q && s_done_q) state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q != ST_IDLE);
    load     = (state_q == ST_IDLE) && !fifo_empty;
    sts_rdy  = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
    fifo_pop = (state_q == ST_DONE);
  end

  always_comb begin
    src_d      = src_q;
    dst_d      = dst_q;
    irq_en_d   = irq_en_q;
    irq_pend_d = irq_pend_q;
    err_cfg_d  = err_cfg_q;
    err_xfer_d = err_xfer_q;
    done_cnt_d = done_cnt_q;
    bad_byte_d = bad_byte_q;
    tag_d      = tag_q;
    h_cmd_d    = h_cmd_q;
    s_cmd_d    = s_cmd_q;
    h_vld_d    = h_vld_q;
    s_vld_d    = s_vld_q;
    h_done_d   = h_done_q;
    s_done_d   = s_done_q;
    h_sts_d    = h_sts_q;
    s_sts_d    = s_sts_q;
    h_bad      = sts_bad(h_sts_q, tag_q);
    s_bad      = sts_bad(s_sts_q, tag_q);

    if (set_stb && set_addr[4:2] == 3'(REG_SRC)) src_d = set_data[31:0];
    if (set_stb && set_addr[4:2] == 3'(REG_DST)) dst_d = set_data[31:0];
    if (wr_ctrl) begin
      irq_en_d = set_data[2];
      if (set_data[0]) irq_pend_d = 1'b0;
      if (set_data[1]) begin
        err_cfg_d  = 1'b0;
        err_xfer_d = 1'b0;
      end
    end
    if (wr_len && !fifo_push) err_cfg_d = 1'b1;

    if (load) begin
      h_cmd_d  = fmt_cmd(fifo_rdata[DESC_W-1 -: 32], fifo_rdata[LEN_W-1:0], tag_q);
      s_cmd_d  = fmt_cmd(fifo_rdata[LEN_W +: 32], fifo_rdata[LEN_W-1:0], tag_q);
      h_vld_d  = 1'b1;
      s_vld_d  = 1'b1;
      h_done_d = 1'b0;
      s_done_d = 1'b0;
    end
    if (h_vld_q && h2s_cmd_tready) h_vld_d = 1'b0;
    if (s_vld_q && s2h_cmd_tready) s_vld_d = 1'b0;

    // Only the first beat per channel is captured; later beats are drained.
    if (sts_rdy && h2s_sts_tvalid && !h_done_q) begin
      h_done_d = 1'b1;
      h_sts_d  = h2s_sts_tdata;
    end
    if (sts_rdy && s2h_sts_tvalid && !s_done_q) begin
      s_done_d = 1'b1;
      s_sts_d  = s2h_sts_tdata;
    end

    if (fifo_pop) begin
      done_cnt_d = done_cnt_q + 8'd1;
      tag_d      = tag_q + 4'd1;
      irq_pend_d = 1'b1;
      if (h_bad || s_bad) err_xfer_d = 1'b1;
      if (h_bad)      bad_byte_d = h_sts_q;
      else if (s_bad) bad_byte_d = s_sts_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      src_q <= '0; dst_q <= '0;
      irq_en_q <= 1'b0; irq_pend_q <= 1'b0;
      err_cfg_q <= 1'b0; err_xfer_q <= 1'b0;
      done_cnt_q <= '0; bad_byte_q <= '0; tag_q <= '0;
      h_cmd_q <= '0; s_cmd_q <= '0;
      h_vld_q <= 1'b0; s_vld_q <= 1'b0;
      h_done_q <= 1'b0; s_done_q <= 1'b0;
      h_sts_q <= '0; s_sts_q <= '0;
    end else begin
      src_q <= src_d; dst_q <= dst_d;
      irq_en_q <= irq_en_d; irq_pend_q <= irq_pend_d;
      err_cfg_q <= err_cfg_d; err_xfer_q <= err_xfer_d;
      done_cnt_q <= done_cnt_d; bad_byte_q <= bad_byte_d; tag_q <= tag_d;
      h_cmd_q <= h_cmd_d; s_cmd_q <= s_cmd_d;
      h_vld_q <= h_vld_d; s_vld_q <= s_vld_d;
      h_done_q <= h_done_d; s_done_q <= s_done_d;
      h_sts_q <= h_sts_d; s_sts_q <= s_sts_d;
    end
  end

  assign status_w = {done_cnt_q, bad_byte_q, tag_q, 4'(fifo_level), 5'b0,
                     err_cfg_q, err_xfer_q, busy};

  always_comb begin
    get_data = '0;
    if (get_addr[4:2] == 3'(REG_STATUS)) get_data = C_S_AXI_DATA_WIDTH'(status_w);
  end

  assign h2s_cmd_tvalid = h_vld_q;
  assign h2s_cmd_tdata  = h_cmd_q;
  assign s2h_cmd_tvalid = s_vld_q;
  assign s2h_cmd_tdata  = s_cmd_q;
  assign h2s_sts_tready = sts_rdy;
  assign s2h_sts_tready = sts_rdy;
  assign irq = irq_en_q && (irq_pend_q || err_xfer_q || err_cfg_q);

  assign unused_bits = ^{set_addr[C_S_AXI_ADDR_WIDTH-1:5], set_addr[1:0],
                         get_addr[C_S_AXI_ADDR_WIDTH-1:5], get_addr[1:0], get_stb};

endmodule
